// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and types for the fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_fetch_unit_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_INSTR_W = 32;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
  // Clears the byte-offset bits of a PC so every fetch is word aligned.
  localparam logic [63:0] PC_ALIGN_MASK    = ~64'(INSTR_BYTES - 1);

  // Decode-side entry layout at the default widths.
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
  } fifo_entry_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch unit.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on imem request and decode output; imem response never stalls.
interface pc_fetch_unit_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;

  // Fetch unit side.
  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           instr_ready,
    output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc
  );

  // Next-PC logic, memory and decode side.
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           instr_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc
  );
endinterface

// File: rtl/pc_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// Latency: write visible at pop_dat the cycle after push.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers and occupancy; flush empties the queue and wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: the count gates what is ever read out.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC holder: issues in-order imem reads, returns {instr,pc} to decode, flushes on redirect.
// Latency: response to instr_valid 1 cycle; redirect to first new request 1 cycle.
// Backpressure: credit of FIFO_DEPTH covers in-flight + queued; decode stall throttles requests.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                INSTR_W    = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed,
`endif
  pc_fetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     tag_count;
  logic [CW-1:0]     ifq_count;
  logic [CW-1:0]     in_use;
  logic [CW-1:0]     out_next;
  logic [ADDR_W-1:0] tag_pc;
  entry_t            ifq_wdat;
  entry_t            ifq_rdat;
  logic              ifq_empty;
  logic              pop;
  logic              req_fire;
  logic              rsp_fire;
  logic              rsp_keep;

  // Credit, handshakes and response steering. The tag queue count is the outstanding count;
  // a slot freed by this cycle's decode pop is reusable so 1-cycle memory streams at full rate.
  always_comb begin
    ifq_empty          = (ifq_count == '0);
    bus.instr_valid    = ~ifq_empty & ~bus.redirect_valid & ~RESET;
    pop                = bus.instr_valid & bus.instr_ready;
    in_use             = tag_count + ifq_count - CW'(pop);
    bus.imem_req_valid = (in_use < CW'(FIFO_DEPTH)) & ~bus.redirect_valid & ~RESET;
    bus.imem_req_addr  = fetch_pc;
    req_fire           = bus.imem_req_valid & bus.imem_req_ready;
    rsp_fire           = bus.imem_rsp_valid & (tag_count != '0);
    rsp_keep           = rsp_fire & (drop == '0) & ~bus.redirect_valid;
    out_next           = tag_count + CW'(req_fire) - CW'(rsp_fire);
    ifq_wdat.instr     = bus.imem_rsp_data;
    ifq_wdat.pc        = tag_pc;
    bus.instr_data     = ifq_rdat.instr;
    bus.instr_pc       = ifq_rdat.pc;
  end

  // Fetch PC and drop counter; a redirect drops every fetch still in flight after this cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_pc <= RESET_PC;
      drop     <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc & ADDR_W'(PC_ALIGN_MASK);
      drop     <= out_next;
    end else begin
      if (req_fire)                fetch_pc <= fetch_pc + ADDR_W'(INSTR_BYTES);
      if (rsp_fire && drop != '0)  drop     <= drop - CW'(1);
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ADDR_W)) u_tag_q (
    .clk      (CLK),
    .rst      (RESET),
    .flush    (1'b0),
    .push     (req_fire),
    .push_dat (fetch_pc),
    .pop      (rsp_fire),
    .pop_dat  (tag_pc),
    .count    (tag_count)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(entry_t))) u_instr_q (
    .clk      (CLK),
    .rst      (RESET),
    .flush    (bus.redirect_valid),
    .push     (rsp_keep),
    .push_dat (ifq_wdat),
    .pop      (pop),
    .pop_dat  (ifq_rdat),
    .count    (ifq_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [CW-1:0] flush_now;

  // Work thrown away this cycle: queued entries on a redirect plus any discarded response.
  always_comb begin
    flush_now = (bus.redirect_valid ? ifq_count : '0) + CW'(rsp_fire & ~rsp_keep);
  end

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_flushed <= perf_flushed + 32'(flush_now);
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a 1-cycle in-order memory model and a PC-order scoreboard.
// Latency: n/a.
// Backpressure: memory responses can be held; decode ready is driven per test.
module tb_pc_fetch_unit;
  localparam int AW = 64;
  localparam int IW = 32;
  localparam logic [AW-1:0] HI_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic CLK = 1'b0;
  logic RESET;
  logic rst_b;

  always #5 CLK = ~CLK;

  pc_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();
  pc_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus_b ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf_fetched, pf_flushed, pfb_fetched, pfb_flushed;
`endif

  pc_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(64'h0), .FIFO_DEPTH(2)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched (pf_fetched),
    .perf_flushed (pf_flushed),
`endif
    .bus          (bus)
  );

  pc_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(HI_PC), .FIFO_DEPTH(2)) dut_b (
    .CLK          (CLK),
    .RESET        (rst_b),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched (pfb_fetched),
    .perf_flushed (pfb_flushed),
`endif
    .bus          (bus_b)
  );

  int n_vec, n_bad, n_req, n_pop;
  logic hold;
  logic [AW-1:0] pend[$];
  logic [AW-1:0] exp_pc;
  logic          s_req_vld, s_ivld;
  logic [AW-1:0] s_req_addr, s_ipc;
  logic [IW-1:0] s_idat;

  function automatic logic [IW-1:0] mdat(input logic [AW-1:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One cycle: present the memory response, sample at negedge+1, track issues and pops.
  task automatic cyc();
    if (!hold && pend.size() > 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mdat(pend[0]);
      void'(pend.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    #1;
    s_req_vld  = bus.imem_req_valid;
    s_req_addr = bus.imem_req_addr;
    s_ivld     = bus.instr_valid;
    s_ipc      = bus.instr_pc;
    s_idat     = bus.instr_data;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      pend.push_back(bus.imem_req_addr);
      n_req++;
    end
    if (bus.instr_valid && bus.instr_ready) begin
      chk("pop_pc", bus.instr_pc, exp_pc);
      chk("pop_dat", 64'(bus.instr_data), 64'(mdat(exp_pc)));
      exp_pc = exp_pc + 64'd4;
      n_pop++;
    end
    if (bus.redirect_valid) exp_pc = bus.redirect_pc & ~64'h3;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    pend.delete();
    hold = 1'b0;
    bus.redirect_valid = 1'b0;
    exp_pc = '0;
    repeat (2) cyc();
    RESET = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; n_req = 0; n_pop = 0;
    hold = 1'b0; RESET = 1'b1; rst_b = 1'b1; exp_pc = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0; bus.instr_ready = 1'b1;
    bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = '0; bus_b.imem_req_ready = 1'b1;
    bus_b.imem_rsp_valid = 1'b0; bus_b.imem_rsp_data = '0; bus_b.instr_ready = 1'b1;
    @(negedge CLK);

    // Reset state and 1: streaming from RESET_PC
    do_reset();
    chk("rst_req_vld", 64'(s_req_vld), 64'd0);
    chk("rst_ivld", 64'(s_ivld), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", 64'(pf_fetched), 64'd0);
    chk("rst_perf_flushed", 64'(pf_flushed), 64'd0);
`endif
    cyc();
    chk("t1_req0_vld", 64'(s_req_vld), 64'd1);
    chk("t1_req0_addr", s_req_addr, 64'h0);
    chk("t1_c0_ivld", 64'(s_ivld), 64'd0);
    cyc();
    chk("t1_req1_addr", s_req_addr, 64'h4);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t1_ivld", 64'(s_ivld), 64'd1);
      chk("t1_pc", s_ipc, 64'(4 * k));
    end

    // 2: decode stall limits issue to the credit, then resumes in order
    bus.instr_ready = 1'b0;
    do_reset();
    n_req = 0;
    repeat (6) cyc();
    chk("t2_nreq", 64'(n_req), 64'd2);
    chk("t2_stall_req_vld", 64'(s_req_vld), 64'd0);
    bus.instr_ready = 1'b1;
    n_pop = 0;
    repeat (8) cyc();
    chk("t2_npop", 64'(n_pop), 64'd8);

    // 3: redirect with two requests outstanding
    do_reset();
    hold = 1'b1;
    repeat (3) cyc();
    chk("t3_credit_full", 64'(s_req_vld), 64'd0);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h100;
    cyc();
    bus.redirect_valid = 1'b0;
    chk("t3_redir_req_vld", 64'(s_req_vld), 64'd0);
    hold = 1'b0;
    cyc();
    chk("t3_c4_req_vld", 64'(s_req_vld), 64'd0);
    cyc();
    chk("t3_c5_req_vld", 64'(s_req_vld), 64'd1);
    chk("t3_c5_req_addr", s_req_addr, 64'h100);
    cyc();
    chk("t3_no_stale", 64'(s_ivld), 64'd0);
    cyc();
    chk("t3_ivld", 64'(s_ivld), 64'd1);
    chk("t3_pc", s_ipc, 64'h100);
`ifdef FETCH_PERF_CNT_EN
    chk("t3_perf_flushed", 64'(pf_flushed), 64'd2);
    chk("t3_perf_fetched", 64'(pf_fetched), 64'd1);
`endif

    // 4: redirect to an unaligned target in the same cycle as a response
    repeat (2) cyc();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h203;
    cyc();
    bus.redirect_valid = 1'b0;
    chk("t4_redir_ivld", 64'(s_ivld), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("t4_perf_flushed", 64'(pf_flushed), 64'd4);
`endif
    cyc();
    chk("t4_req_vld", 64'(s_req_vld), 64'd1);
    chk("t4_req_addr", s_req_addr, 64'h200);
    cyc();
    cyc();
    chk("t4_pc", s_ipc, 64'h200);
    repeat (2) cyc();

    // Back-to-back redirects with a held response: the last target wins
    hold = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h300;
    cyc();
    bus.redirect_pc = 64'h404;
    cyc();
    bus.redirect_valid = 1'b0;
    hold = 1'b0;
    cyc();
    chk("b2b_req_addr", s_req_addr, 64'h404);
    chk("b2b_req_vld", 64'(s_req_vld), 64'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("b2b_perf_flushed", 64'(pf_flushed), 64'd6);
`endif
    cyc();
    cyc();
    chk("b2b_ivld", 64'(s_ivld), 64'd1);
    chk("b2b_pc", s_ipc, 64'h404);

    // 6: reset with a queued entry and an outstanding request
    bus.instr_ready = 1'b0;
    do_reset();
    cyc();
    cyc();
    hold = 1'b1;
    cyc();
    chk("t6_pre_ivld", 64'(s_ivld), 64'd1);
    RESET = 1'b1;
    exp_pc = '0;
    cyc();
    chk("t6_rst_ivld", 64'(s_ivld), 64'd0);
    RESET = 1'b0;
    hold = 1'b0;
    bus.instr_ready = 1'b1;
    cyc();
    chk("t6_after_ivld", 64'(s_ivld), 64'd0);
    chk("t6_restart_addr", s_req_addr, 64'h0);
    chk("t6_restart_vld", 64'(s_req_vld), 64'd1);
    cyc();
    cyc();
    chk("t6_pc", s_ipc, 64'h0);
    chk("t6_dat", 64'(s_idat), 64'(mdat(64'h0)));

    // Request address holds while memory is not ready
    bus.imem_req_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("hold_vld", 64'(s_req_vld), 64'd1);
      chk("hold_addr", s_req_addr, 64'h0);
    end
    bus.imem_req_ready = 1'b1;
    cyc();
    chk("hold_fire_addr", s_req_addr, 64'h0);
    cyc();
    chk("hold_next_addr", s_req_addr, 64'h4);

    // 5: PC wrap from the top of the address space (second instance)
    RESET = 1'b1;
    rst_b = 1'b0;
    #1;
    chk("t5_vld0", 64'(bus_b.imem_req_valid), 64'd1);
    chk("t5_addr0", bus_b.imem_req_addr, HI_PC);
    @(negedge CLK);
    bus_b.imem_rsp_valid = 1'b1;
    bus_b.imem_rsp_data  = mdat(HI_PC);
    #1;
    chk("t5_vld1", 64'(bus_b.imem_req_valid), 64'd1);
    chk("t5_addr1", bus_b.imem_req_addr, 64'h0);
    @(negedge CLK);
    bus_b.imem_rsp_data = mdat(64'h0);
    #1;
    chk("t5_ivld", 64'(bus_b.instr_valid), 64'd1);
    chk("t5_pc", bus_b.instr_pc, HI_PC);
    @(negedge CLK);
    bus_b.imem_rsp_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    #1;
    chk("t5_perf_fetched", 64'(pfb_fetched), 64'd1);
`endif
    rst_b = 1'b1;
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
